// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch,
// decode, execute, memory and write-back, plus retire counter and trap flag.
module multicycle_ctrl #(
    parameter int ALU_CTRL_W    = 4,
    parameter int CNT_W         = 32,
    parameter int MEM_HANDSHAKE = 1,
    parameter int TRAP_HALT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  zero,
    input  logic [5:0]            operation,
    input  logic [5:0]            func,
    input  logic                  mem_ready,
    output logic [1:0]            alu_src_a,
    output logic [2:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic                  instr_or_data,
    output logic                  instr_reg_we,
    output logic                  reg_we,
    output logic [1:0]            reg_write_addr,
    output logic [1:0]            reg_write_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  pc_reg_we,
    output logic [ALU_CTRL_W-1:0] alu_controller,
    output logic                  illegal_instr,
    output logic [CNT_W-1:0]      retired,
    output logic [4:0]            state_dbg
);

    typedef enum logic [4:0] {
        S_FETCH    = 5'd0,
        S_DECODE   = 5'd1,
        S_MEMADDR  = 5'd2,
        S_MEMREAD  = 5'd3,
        S_MEMWRITE = 5'd4,
        S_MEMWB    = 5'd5,
        S_BEQ      = 5'd6,
        S_BNE      = 5'd7,
        S_JUMP     = 5'd8,
        S_JAL      = 5'd9,
        S_JR       = 5'd10,
        S_SHIFT    = 5'd11,
        S_REXEC    = 5'd12,
        S_IMMEXEC  = 5'd13,
        S_ALUWB    = 5'd14,
        S_IMMWB    = 5'd15,
        S_TRAP     = 5'd16
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [3:0] A_AND = 4'd0;
    localparam logic [3:0] A_OR  = 4'd1;
    localparam logic [3:0] A_ADD = 4'd2;
    localparam logic [3:0] A_SLL = 4'd3;
    localparam logic [3:0] A_SRL = 4'd4;
    localparam logic [3:0] A_SRA = 4'd5;
    localparam logic [3:0] A_SUB = 4'd6;
    localparam logic [3:0] A_SLT = 4'd7;
    localparam logic [3:0] A_XOR = 4'd8;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       func_q, func_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             rdy;
    logic             rexec_ok;
    logic [3:0]       rexec_alu;
    logic [3:0]       alu_code;

    // Memory completion, optionally forced when the bus has no handshake
    assign rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

    // R-type funct decode for the execute state; flags unknown functs
    always_comb begin
        rexec_ok  = 1'b1;
        rexec_alu = A_ADD;
        case (func_q)
            F_AND:   rexec_alu = A_AND;
            F_OR:    rexec_alu = A_OR;
            F_ADD:   rexec_alu = A_ADD;
            F_SUB:   rexec_alu = A_SUB;
            F_SLT:   rexec_alu = A_SLT;
            F_XOR:   rexec_alu = A_XOR;
            F_SLLV:  rexec_alu = A_SLL;
            F_SRLV:  rexec_alu = A_SRL;
            F_SRAV:  rexec_alu = A_SRA;
            default: rexec_ok  = 1'b0;
        endcase
    end

    // Next-state logic; opcode/funct are captured while in Decode
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        func_d  = func_q;
        unique case (state_q)
            S_FETCH: begin
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d   = operation;
                func_d = func;
                case (operation)
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_XORI, OP_SLTI:
                                  state_d = S_IMMEXEC;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_R: begin
                        if (func == F_JR)
                            state_d = S_JR;
                        else if (func == F_SLL || func == F_SRL ||
                                 func == F_SRA)
                            state_d = S_SHIFT;
                        else
                            state_d = S_REXEC;
                    end
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                state_d = (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (rdy) state_d = S_FETCH;
            end
            S_MEMWB, S_BEQ, S_BNE, S_JUMP, S_JAL, S_JR,
            S_ALUWB, S_IMMWB: begin
                state_d = S_FETCH;
            end
            S_SHIFT:   state_d = S_ALUWB;
            S_REXEC:   state_d = rexec_ok ? S_ALUWB : S_TRAP;
            S_IMMEXEC: state_d = S_IMMWB;
            S_TRAP:    state_d = (TRAP_HALT != 0) ? S_TRAP : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // Retire count bumps on any return to Fetch except from Trap
    always_comb begin
        retired_d = retired_q;
        if (state_d == S_FETCH && state_q != S_FETCH &&
            state_q != S_TRAP)
            retired_d = retired_q + CNT_W'(1);
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // State, captured instruction fields, counter and sticky trap flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            func_q    <= 6'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            func_q    <= func_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore output decode; strobes are forced low while reset is held
    always_comb begin
        alu_src_a      = 2'b00;
        alu_src_b      = 3'b000;
        pc_src         = 2'b00;
        instr_or_data  = 1'b0;
        instr_reg_we   = 1'b0;
        reg_we         = 1'b0;
        reg_write_addr = 2'b00;
        reg_write_data = 2'b00;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        pc_reg_we      = 1'b0;
        alu_code       = A_ADD;
        unique case (state_q)
            S_FETCH: begin
                mem_req      = 1'b1;
                alu_src_b    = 3'b001;
                instr_reg_we = rdy;
                pc_reg_we    = rdy;
            end
            S_DECODE: begin
                alu_src_b = 3'b011;
            end
            S_MEMADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 3'b010;
            end
            S_MEMREAD: begin
                mem_req       = 1'b1;
                instr_or_data = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req       = 1'b1;
                instr_or_data = 1'b1;
                mem_we        = 1'b1;
            end
            S_MEMWB: begin
                reg_we         = 1'b1;
                reg_write_data = 2'b01;
            end
            S_BEQ, S_BNE: begin
                alu_src_a = 2'b01;
                pc_src    = 2'b01;
                alu_code  = A_SUB;
                pc_reg_we = (state_q == S_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_reg_we = 1'b1;
            end
            S_JAL: begin
                pc_src         = 2'b10;
                pc_reg_we      = 1'b1;
                reg_we         = 1'b1;
                reg_write_addr = 2'b10;
                reg_write_data = 2'b10;
            end
            S_JR: begin
                pc_src    = 2'b11;
                pc_reg_we = 1'b1;
            end
            S_SHIFT: begin
                alu_src_a = 2'b10;
                alu_src_b = 3'b100;
                case (func_q)
                    F_SLL:   alu_code = A_SLL;
                    F_SRL:   alu_code = A_SRL;
                    F_SRA:   alu_code = A_SRA;
                    default: alu_code = A_ADD;
                endcase
            end
            S_REXEC: begin
                alu_src_a = 2'b01;
                alu_code  = rexec_alu;
            end
            S_IMMEXEC: begin
                alu_src_a = 2'b01;
                case (op_q)
                    OP_ANDI: begin
                        alu_src_b = 3'b101;
                        alu_code  = A_AND;
                    end
                    OP_ORI: begin
                        alu_src_b = 3'b101;
                        alu_code  = A_OR;
                    end
                    OP_XORI: begin
                        alu_src_b = 3'b101;
                        alu_code  = A_XOR;
                    end
                    OP_SLTI: begin
                        alu_src_b = 3'b010;
                        alu_code  = A_SLT;
                    end
                    default: begin
                        alu_src_b = 3'b010;
                        alu_code  = A_ADD;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_we         = 1'b1;
                reg_write_addr = 2'b01;
            end
            S_IMMWB: begin
                reg_we = 1'b1;
            end
            S_TRAP: begin
                alu_code = A_ADD;
            end
            default: begin
                alu_code = A_ADD;
            end
        endcase
        if (rst) begin
            instr_reg_we = 1'b0;
            reg_we       = 1'b0;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            pc_reg_we    = 1'b0;
        end
    end

    assign alu_controller = ALU_CTRL_W'(alu_code);
    assign illegal_instr  = illegal_q;
    assign retired        = retired_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instructions plus
// hand sequences for memory stalls, traps and reset during a memory wait.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       zero = 1'b0;
    logic [5:0] operation = 6'd0;
    logic [5:0] func = 6'd0;
    logic       mem_ready = 1'b1;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_src;
    logic       instr_or_data;
    logic       instr_reg_we;
    logic       reg_we;
    logic [1:0] reg_write_addr;
    logic [1:0] reg_write_data;
    logic       mem_req;
    logic       mem_we;
    logic       pc_reg_we;
    logic [3:0] alu_controller;
    logic       illegal_instr;
    logic [3:0] retired;
    logic [4:0] state_dbg;

    multicycle_ctrl #(
        .ALU_CTRL_W(4),
        .CNT_W(4),
        .MEM_HANDSHAKE(1),
        .TRAP_HALT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .zero(zero),
        .operation(operation),
        .func(func),
        .mem_ready(mem_ready),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .pc_src(pc_src),
        .instr_or_data(instr_or_data),
        .instr_reg_we(instr_reg_we),
        .reg_we(reg_we),
        .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .pc_reg_we(pc_reg_we),
        .alu_controller(alu_controller),
        .illegal_instr(illegal_instr),
        .retired(retired),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mr;
        logic [4:0] st;
        logic [3:0] alu;
        logic [1:0] srca;
        logic [2:0] srcb;
        logic [1:0] pcsrc;
        logic [1:0] rwa;
        logic [1:0] rwd;
        logic       pcwe;
        logic       irwe;
        logic       regwe;
        logic       memwe;
        logic       memreq;
        logic       iod;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic [4:0] st1;
        logic [3:0] alu1;
        logic [2:0] srcb1;
        logic       pcwe1;
        logic [4:0] st2;
        logic [4:0] st3;
    } vec_t;

    localparam logic [4:0] NONE = 5'd31;

    exp_t       q[$];
    vec_t       tbl[22];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] exp_ret = 4'd0;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected outputs of a state, from the per-state output table
    function automatic exp_t ex(input logic mr, input logic [4:0] st,
                                input logic [3:0] alu,
                                input logic [2:0] srcb,
                                input logic pcwe);
        exp_t e;
        e = '0;
        e.mr = mr;
        e.st = st;
        e.alu = alu;
        e.srcb = srcb;
        e.pcwe = pcwe;
        case (st)
            5'd0: begin e.memreq = 1'b1; e.irwe = pcwe; end
            5'd2: e.srca = 2'b01;
            5'd3: begin e.memreq = 1'b1; e.iod = 1'b1; end
            5'd4: begin
                e.memreq = 1'b1; e.iod = 1'b1; e.memwe = 1'b1;
            end
            5'd5: begin e.regwe = 1'b1; e.rwd = 2'b01; end
            5'd6, 5'd7: begin e.srca = 2'b01; e.pcsrc = 2'b01; end
            5'd8: e.pcsrc = 2'b10;
            5'd9: begin
                e.pcsrc = 2'b10; e.regwe = 1'b1;
                e.rwa = 2'b10; e.rwd = 2'b10;
            end
            5'd10: e.pcsrc = 2'b11;
            5'd11: e.srca = 2'b10;
            5'd12, 5'd13: e.srca = 2'b01;
            5'd14: begin e.regwe = 1'b1; e.rwa = 2'b01; end
            5'd15: e.regwe = 1'b1;
            5'd16: e.ill = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t mkv(input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic [4:0] st1,
                                 input logic [3:0] alu1,
                                 input logic [2:0] srcb1,
                                 input logic pcwe1, input logic [4:0] st2,
                                 input logic [4:0] st3);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.st1 = st1; v.alu1 = alu1;
        v.srcb1 = srcb1; v.pcwe1 = pcwe1; v.st2 = st2; v.st3 = st3;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] x);
        n_cmp++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, a, x);
        end
    endtask

    // Pop expected cycles, drive mem_ready for each, compare all outputs
    task automatic drain(input string nm);
        exp_t e, act;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_ready = e.mr;
            #1;
            act = '0;
            act.mr = e.mr;
            act.st = state_dbg;
            act.alu = alu_controller;
            act.srca = alu_src_a;
            act.srcb = alu_src_b;
            act.pcsrc = pc_src;
            act.rwa = reg_write_addr;
            act.rwd = reg_write_data;
            act.pcwe = pc_reg_we;
            act.irwe = instr_reg_we;
            act.regwe = reg_we;
            act.memwe = mem_we;
            act.memreq = mem_req;
            act.iod = instr_or_data;
            act.ill = illegal_instr;
            n_cmp++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h (st %0d) want %h (st %0d)",
                         nm, act, act.st, e, e.st);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_fd();
        q.push_back(ex(1'b1, 5'd0, 4'd2, 3'b001, 1'b1));
        q.push_back(ex(rnd(), 5'd1, 4'd2, 3'b011, 1'b0));
    endtask

    function automatic logic fol_mr(input logic [4:0] st);
        return (st == 5'd3 || st == 5'd4) ? 1'b1 : rnd();
    endfunction

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        chk("rst_ill", 32'(illegal_instr), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 4'd0;
        #1;
        chk("rst_ret", 32'(retired), 32'd0);
    endtask

    initial begin
        tbl[0]  = mkv(6'h00, 6'b100000, 0, 12, 2, 0, 0, 14, NONE);
        tbl[1]  = mkv(6'h00, 6'b100010, 0, 12, 6, 0, 0, 14, NONE);
        tbl[2]  = mkv(6'h00, 6'b100110, 0, 12, 8, 0, 0, 14, NONE);
        tbl[3]  = mkv(6'h00, 6'b101010, 0, 12, 7, 0, 0, 14, NONE);
        tbl[4]  = mkv(6'h00, 6'b000100, 0, 12, 3, 0, 0, 14, NONE);
        tbl[5]  = mkv(6'h00, 6'b000111, 0, 12, 5, 0, 0, 14, NONE);
        tbl[6]  = mkv(6'h00, 6'b000000, 0, 11, 3, 4, 0, 14, NONE);
        tbl[7]  = mkv(6'h00, 6'b000011, 0, 11, 5, 4, 0, 14, NONE);
        tbl[8]  = mkv(6'h00, 6'b001000, 0, 10, 2, 0, 1, NONE, NONE);
        tbl[9]  = mkv(6'b001000, 0, 0, 13, 2, 2, 0, 15, NONE);
        tbl[10] = mkv(6'b001100, 0, 0, 13, 0, 5, 0, 15, NONE);
        tbl[11] = mkv(6'b001110, 0, 0, 13, 8, 5, 0, 15, NONE);
        tbl[12] = mkv(6'b001010, 0, 0, 13, 7, 2, 0, 15, NONE);
        tbl[13] = mkv(6'b000100, 0, 1, 6, 6, 0, 1, NONE, NONE);
        tbl[14] = mkv(6'b000100, 0, 0, 6, 6, 0, 0, NONE, NONE);
        tbl[15] = mkv(6'b000101, 0, 0, 7, 6, 0, 1, NONE, NONE);
        tbl[16] = mkv(6'b000101, 0, 1, 7, 6, 0, 0, NONE, NONE);
        tbl[17] = mkv(6'b000010, 0, 0, 8, 2, 0, 1, NONE, NONE);
        tbl[18] = mkv(6'b000011, 0, 0, 9, 2, 0, 1, NONE, NONE);
        tbl[19] = mkv(6'b100011, 0, 0, 2, 2, 2, 0, 3, 5);
        tbl[20] = mkv(6'b101011, 0, 0, 2, 2, 2, 0, 4, NONE);
        tbl[21] = mkv(6'b001101, 0, 0, 13, 1, 5, 0, 15, NONE);

        // Reset held: strobes low, Fetch, counters cleared
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memreq", 32'(mem_req), 32'd0);
        chk("rst_pcwe", 32'(pc_reg_we), 32'd0);
        chk("rst_irwe", 32'(instr_reg_we), 32'd0);
        chk("rst_st", 32'(state_dbg), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_illegal", 32'(illegal_instr), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_memreq", 32'(mem_req), 32'd1);
        chk("rel_srcb", 32'(alu_src_b), 32'd1);

        // Fetch waits on mem_ready without loading IR or PC
        q.push_back(ex(1'b0, 5'd0, 4'd2, 3'b001, 1'b0));
        q.push_back(ex(1'b0, 5'd0, 4'd2, 3'b001, 1'b0));
        drain("fetch_stall");

        // Instruction table; counter is 4 bits so it wraps past 15
        for (int i = 0; i < 22; i++) begin
            operation = tbl[i].op;
            func = tbl[i].fn;
            zero = tbl[i].z;
            push_fd();
            q.push_back(ex(rnd(), tbl[i].st1, tbl[i].alu1,
                           tbl[i].srcb1, tbl[i].pcwe1));
            if (tbl[i].st2 != NONE)
                q.push_back(ex(fol_mr(tbl[i].st2), tbl[i].st2,
                               4'd2, 3'b000, 1'b0));
            if (tbl[i].st3 != NONE)
                q.push_back(ex(fol_mr(tbl[i].st3), tbl[i].st3,
                               4'd2, 3'b000, 1'b0));
            drain($sformatf("vec%0d", i));
            exp_ret = exp_ret + 4'd1;
            chk($sformatf("vec%0d_retired", i), 32'(retired),
                32'(exp_ret));
        end

        // LW with three stalled MemRead cycles
        operation = 6'b100011;
        func = 6'd0;
        push_fd();
        q.push_back(ex(rnd(), 5'd2, 4'd2, 3'b010, 1'b0));
        repeat (3) q.push_back(ex(1'b0, 5'd3, 4'd2, 3'b000, 1'b0));
        q.push_back(ex(1'b1, 5'd3, 4'd2, 3'b000, 1'b0));
        q.push_back(ex(rnd(), 5'd5, 4'd2, 3'b000, 1'b0));
        drain("lw_stall");
        exp_ret = exp_ret + 4'd1;
        chk("lw_retired", 32'(retired), 32'(exp_ret));

        // Reset asserted in the middle of a MemWrite wait
        operation = 6'b101011;
        push_fd();
        q.push_back(ex(rnd(), 5'd2, 4'd2, 3'b010, 1'b0));
        repeat (2) q.push_back(ex(1'b0, 5'd4, 4'd2, 3'b000, 1'b0));
        drain("sw_wait");
        chk("sw_hold_st", 32'(state_dbg), 32'd4);
        chk("sw_hold_memwe", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("sw_rst_memwe", 32'(mem_we), 32'd0);
        chk("sw_rst_memreq", 32'(mem_req), 32'd0);
        chk("sw_rst_st", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_ret = 4'd0;
        mem_ready = 1'b1;
        #1;
        chk("sw_rel_st", 32'(state_dbg), 32'd0);
        chk("sw_rel_ret", 32'(retired), 32'd0);
        chk("sw_rel_memreq", 32'(mem_req), 32'd1);

        // Unknown R-type funct traps from RExec and halts there
        operation = 6'd0;
        func = 6'b111111;
        push_fd();
        q.push_back(ex(rnd(), 5'd12, 4'd2, 3'b000, 1'b0));
        repeat (3) q.push_back(ex(rnd(), 5'd16, 4'd2, 3'b000, 1'b0));
        drain("rexec_trap");
        chk("rexec_trap_ret", 32'(retired), 32'(exp_ret));
        pulse_rst();

        // Undefined opcode traps from Decode and halts there
        operation = 6'b111111;
        func = 6'd0;
        push_fd();
        repeat (4) q.push_back(ex(rnd(), 5'd16, 4'd2, 3'b000, 1'b0));
        drain("op_trap");
        chk("op_trap_ret", 32'(retired), 32'(exp_ret));
        pulse_rst();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ALU_CTRL_W, default 4, width of alu_controller; legal values are 4 and above.
REQ-002 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-003 SHALL have parameter MEM_HANDSHAKE, default 1; when 0, mem_ready is ignored and treated as 1.
REQ-004 SHALL have parameter TRAP_HALT, default 1; when 1, Trap is terminal; when 0, Trap returns to Fetch.
REQ-005 SHALL have one clock and an asynchronous active-high reset, exposed as these ports:
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  zero  in  1  ALU zero flag
  operation  in  6  instruction opcode
  func  in  6  R-type funct
  mem_ready  in  1  memory access completes this cycle
  alu_src_a  out  2  00 PC, 01 regA, 10 regB
  alu_src_b  out  3  000 regB, 001 const 4, 010 sext imm, 011 sext imm<<2, 100 shamt, 101 zext imm
  pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 regA
  instr_or_data  out  1  0 = instruction address, 1 = data address
  instr_reg_we  out  1  instruction register load
  reg_we  out  1  register file write
  reg_write_addr  out  2  00 rt, 01 rd, 10 r31
  reg_write_data  out  2  00 ALUOut, 01 memory data, 10 PC
  mem_req  out  1  memory access request
  mem_we  out  1  memory write
  pc_reg_we  out  1  PC load
  alu_controller  out  ALU_CTRL_W  ALU op code; see REQ-010
  illegal_instr  out  1  sticky trap flag
  retired  out  CNT_W  retired-instruction count
  state_dbg  out  5  current state code

Function
REQ-006 SHALL implement a Moore FSM with states Fetch, Decode, MemAddr, MemRead, MemWrite, MemWB, Beq, Bne, Jump, Jal, Jr, Shift, RExec, ImmExec, AluWB, ImmWB and Trap.
REQ-007 Fetch SHALL drive mem_req=1, instr_or_data=0, alu_src_a=00, alu_src_b=001 and pc_src=00; instr_reg_we and pc_reg_we SHALL be 1 only in the cycle where mem_ready=1; the FSM SHALL stay in Fetch until mem_ready=1, then go to Decode.
REQ-008 Decode SHALL drive alu_src_a=00 and alu_src_b=011, and SHALL dispatch as follows:
  - LW 100011 and SW 101011 -> MemAddr
  - BEQ 000100 -> Beq; BNE 000101 -> Bne
  - ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010 -> ImmExec
  - J 000010 -> Jump; JAL 000011 -> Jal
  - opcode 000000 with func JR 001000 -> Jr; func SLL 000000, SRL 000010, SRA 000011 -> Shift; any other func -> RExec
  - any other opcode -> Trap
REQ-009 Per-state outputs SHALL be as follows; all unlisted outputs are 0 in every state:
  - MemAddr: alu_src_a=01, alu_src_b=010, add; next MemRead (LW) or MemWrite (SW).
  - MemRead: mem_req=1, instr_or_data=1; hold until mem_ready=1, then MemWB.
  - MemWrite: mem_req=1, instr_or_data=1, mem_we=1; hold until mem_ready=1, then Fetch.
  - MemWB: reg_we=1, reg_write_addr=00, reg_write_data=01.
  - Beq/Bne: alu_src_a=01, alu_src_b=000, sub, pc_src=01; pc_reg_we=zero for Beq and ~zero for Bne.
  - Jump: pc_src=10, pc_reg_we=1.
  - Jal: additionally reg_we=1, reg_write_addr=10, reg_write_data=10.
  - Jr: pc_src=11, pc_reg_we=1.
  - Shift: alu_src_a=10, alu_src_b=100.
  - RExec: alu_src_a=01, alu_src_b=000.
  - ImmExec: alu_src_a=01; alu_src_b=101 for ANDI/ORI/XORI, 010 otherwise.
  - AluWB: reg_we=1, reg_write_addr=01, reg_write_data=00.
  - ImmWB: reg_we=1, reg_write_addr=00, reg_write_data=00.
  - Shift and RExec go to AluWB; ImmExec goes to ImmWB; every other non-memory terminal state goes to Fetch.
REQ-010 alu_controller SHALL be zero-extended to ALU_CTRL_W from the code and SHALL be add in any state not listed in REQ-009 as using the ALU:
  - codes: and 0, or 1, add 2, sll/sllv 3, srl/srlv 4, sra/srav 5, sub 6, slt 7, xor 8
  - RExec maps func as: 100100 and, 100101 or, 100000 add, 100010 sub, 101010 slt, 100110 xor, 000100 sllv, 000110 srlv, 000111 srav
  - any other RExec func SHALL go to Trap instead of AluWB.
REQ-011 Trap SHALL set illegal_instr=1, which stays 1 until rst, and SHALL drive all write enables to 0; with TRAP_HALT=0 the next state is Fetch.
REQ-012 retired SHALL increment by 1 on entry to Fetch from any state other than Trap; it SHALL wrap from all-ones to 0.
REQ-013 mem_ready SHALL be ignored outside Fetch, MemRead and MemWrite.
REQ-014 state_dbg SHALL encode Fetch=0, Decode=1, and so on in REQ-006 order, with Trap=16.

Reset
REQ-015 rst=1 SHALL asynchronously force state Fetch, retired=0 and illegal_instr=0, and SHALL abort any in-progress memory wait.
REQ-016 While rst=1, all write enables and mem_req SHALL be 0; after release the FSM SHALL present Fetch outputs.

Verification
REQ-017 LW with mem_ready low for 3 cycles in MemRead -> MemRead holds 3 cycles; MemWB asserts reg_we=1 with reg_write_data=01; retired increments by 1.
REQ-018 BNE with zero=0 -> Bne drives pc_reg_we=1 and pc_src=01; with zero=1 -> pc_reg_we=0.
REQ-019 R-type func 100110 -> RExec, alu_controller=8, then AluWB with reg_we=1.
REQ-020 Opcode 111111 with TRAP_HALT=1 -> Trap with illegal_instr=1; the FSM stays in Trap until rst.
REQ-021 rst asserted during a MemWrite wait -> mem_we drops to 0 immediately; after release the FSM is in Fetch with retired=0.
REQ-022 CNT_W=4 with 16 retired instructions -> retired wraps from 15 to 0.
